// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_IN streams into one output stream.
// The grant is held for a whole packet; the output goes through a two-entry skid buffer.
module stream_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_last,
  input  logic [NUM_IN-1:0]            in_vld,
  output logic [NUM_IN-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [IDX_WIDTH-1:0]         out_idx,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                r_state;
  logic [IDX_WIDTH-1:0]  r_ptr;
  logic [IDX_WIDTH-1:0]  r_grant;
  logic                  r_busy;

  logic                  r_mem_vld;
  logic                  r_mem_last;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [IDX_WIDTH-1:0]  r_mem_idx;

  logic                  r_ext_vld;
  logic                  r_ext_last;
  logic [DATA_WIDTH-1:0] r_ext_data;
  logic [IDX_WIDTH-1:0]  r_ext_idx;

  logic [DATA_WIDTH-1:0] w_in_data [NUM_IN];
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;
  logic                  w_sel_vld;
  logic                  w_in_fire;
  logic                  w_mem_free;
  logic                  w_any;
  logic [IDX_WIDTH:0]    w_cand;
  logic [IDX_WIDTH-1:0]  w_pick;
  logic [IDX_WIDTH-1:0]  w_next_ptr;

  // in_rdy depends only on registered state, never on in_vld.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
      assign w_in_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_rdy[gi]    = (r_state == LOCKED) && (r_grant == IDX_WIDTH'(gi)) && !r_ext_vld;
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    w_sel_vld  = 1'b0;
    for (int j = 0; j < NUM_IN; j++) begin
      if (r_grant == IDX_WIDTH'(j)) begin
        w_sel_data = w_in_data[j];
        w_sel_last = in_last[j];
        w_sel_vld  = in_vld[j];
      end
    end
  end

  // Rotating search from r_ptr; the lowest offset is visited last so it wins.
  always_comb begin
    w_any  = |in_vld;
    w_pick = '0;
    w_cand = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + (IDX_WIDTH+1)'(k);
      if (w_cand >= (IDX_WIDTH+1)'(NUM_IN)) begin
        w_cand = w_cand - (IDX_WIDTH+1)'(NUM_IN);
      end
      for (int j = 0; j < NUM_IN; j++) begin
        if (in_vld[j] && (w_cand == (IDX_WIDTH+1)'(j))) begin
          w_pick = IDX_WIDTH'(j);
        end
      end
    end
  end

  assign w_next_ptr = (r_grant == IDX_WIDTH'(NUM_IN - 1)) ? '0 : r_grant + IDX_WIDTH'(1);
  assign w_in_fire  = (r_state == LOCKED) && w_sel_vld && !r_ext_vld;
  assign w_mem_free = !r_mem_vld || out_rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= LOCKED;
            r_busy  <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_in_fire && w_sel_last) begin
            r_state <= IDLE;
            r_ptr   <= w_next_ptr;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The skid entry drains into mem before any new beat; new beats only land in
  // the skid entry while mem is held by backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_vld  <= 1'b0;
      r_mem_last <= 1'b0;
      r_mem_data <= '0;
      r_mem_idx  <= '0;
      r_ext_vld  <= 1'b0;
      r_ext_last <= 1'b0;
      r_ext_data <= '0;
      r_ext_idx  <= '0;
    end else if (w_mem_free) begin
      if (r_ext_vld) begin
        r_mem_vld  <= 1'b1;
        r_mem_last <= r_ext_last;
        r_mem_data <= r_ext_data;
        r_mem_idx  <= r_ext_idx;
        r_ext_vld  <= 1'b0;
      end else if (w_in_fire) begin
        r_mem_vld  <= 1'b1;
        r_mem_last <= w_sel_last;
        r_mem_data <= w_sel_data;
        r_mem_idx  <= r_grant;
      end else begin
        r_mem_vld  <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_ext_vld  <= 1'b1;
      r_ext_last <= w_sel_last;
      r_ext_data <= w_sel_data;
      r_ext_idx  <= r_grant;
    end
  end

  assign out_vld  = r_mem_vld;
  assign out_data = r_mem_data;
  assign out_last = r_mem_last;
  assign out_idx  = r_mem_idx;
  assign busy     = r_busy;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: per-stream packet sources and an output beat log.
module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_vld;
  logic [N-1:0]    in_rdy;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IW-1:0]   out_idx;
  logic            out_vld;
  logic            out_rdy;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int in_fires = 0;

  int            src_cnt   [N];
  int            src_len   [N];
  int            src_sent  [N];
  int            gap_after [N];
  int            gap_left  [N];
  logic [DW-1:0] src_base  [N];

  int            in_cyc_q [$];
  logic [IW-1:0] oq_idx   [$];
  logic [DW-1:0] oq_data  [$];
  logic          oq_last  [$];

  always #5 clk = ~clk;

  stream_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_last(out_last), .out_idx(out_idx),
    .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      in_vld[i]           = (src_cnt[i] > 0) && (gap_left[i] == 0);
      in_data[i*DW +: DW] = src_base[i] + DW'(src_sent[i]);
      in_last[i]          = ((src_sent[i] + 1) % src_len[i]) == 0;
    end
  endtask

  task automatic src_clear();
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 0; src_len[i] = 1; src_sent[i] = 0;
      gap_after[i] = -1; gap_left[i] = 0; src_base[i] = '0;
    end
  endtask

  task automatic src_load(input int i, input logic [DW-1:0] base, input int len, input int cnt);
    src_base[i] = base; src_len[i] = len; src_cnt[i] = cnt; src_sent[i] = 0;
  endtask

  task automatic clear_q();
    in_cyc_q.delete(); oq_idx.delete(); oq_data.delete(); oq_last.delete();
  endtask

  // Handshakes are captured just before the edge, sources advance just after it.
  task automatic tick();
    logic [N-1:0] fire;
    fire = in_vld & in_rdy;
    if (out_vld && out_rdy) begin
      oq_idx.push_back(out_idx); oq_data.push_back(out_data); oq_last.push_back(out_last);
    end
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) if (gap_left[i] > 0) gap_left[i]--;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        src_sent[i]++; src_cnt[i]--; in_fires++;
        in_cyc_q.push_back(cyc);
        if (src_sent[i] == gap_after[i]) gap_left[i] = 3;
      end
    end
    apply();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int c = 0;
    while (oq_data.size() < n && c < budget) begin
      tick(); c++;
    end
    chk({tag, "_count"}, 64'(oq_data.size()), 64'(n));
  endtask

  function automatic int qcyc(input int k);
    return (k < in_cyc_q.size()) ? in_cyc_q[k] : -1000;
  endfunction

  task automatic exp_beat(input string tag, input int k, input logic [IW-1:0] idx,
                          input logic [DW-1:0] data, input logic last);
    logic [IW-1:0] oi = '1;
    logic [DW-1:0] od = '1;
    logic          ol = 1'b0;
    if (k < oq_data.size()) begin
      oi = oq_idx[k]; od = oq_data[k]; ol = oq_last[k];
    end
    chk($sformatf("%s_idx%0d", tag, k),  64'(oi), 64'(idx));
    chk($sformatf("%s_data%0d", tag, k), od, data);
    chk($sformatf("%s_last%0d", tag, k), 64'(ol), 64'(last));
  endtask

  initial begin
    int f0;
    int c;
    // Reset held with every stream requesting
    rst = 1'b0; out_rdy = 1'b1;
    src_clear();
    for (int s = 0; s < N; s++) src_load(s, DW'(s * 256), 2, 4);
    apply();
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("rst_out_vld", 64'(out_vld), 64'(0));
      chk("rst_in_rdy",  64'(in_rdy),  64'(0));
      chk("rst_busy",    64'(busy),    64'(0));
    end

    // Round robin over 2-beat packets
    rst = 1'b1;
    clear_q();
    run_until(16, 200, "rr");
    for (int p = 0; p < 8; p++)
      for (int b = 0; b < 2; b++)
        exp_beat("rr", 2*p + b, IW'(p % 4), DW'((p % 4) * 256 + (p / 4) * 2 + b), b == 1);
    for (int p = 0; p < 7; p++) begin
      chk("rr_in_packet_spacing", 64'(qcyc(2*p + 1) - qcyc(2*p)), 64'(1));
      chk("rr_between_packets",   64'(qcyc(2*p + 2) - qcyc(2*p + 1)), 64'(2));
    end

    // Lock hold across an in_vld gap while stream 2 waits
    src_clear(); clear_q();
    src_load(1, 'h30, 4, 4); gap_after[1] = 2;
    src_load(2, 'h40, 2, 2);
    apply();
    run_until(6, 100, "lock");
    exp_beat("lock", 0, 1, 'h30, 0);
    exp_beat("lock", 1, 1, 'h31, 0);
    exp_beat("lock", 2, 1, 'h32, 0);
    exp_beat("lock", 3, 1, 'h33, 1);
    exp_beat("lock", 4, 2, 'h40, 0);
    exp_beat("lock", 5, 2, 'h41, 1);

    // Pointer now 3: stream 3 wins over stream 0, then stream 0 single beat
    src_clear(); clear_q();
    chk("wrap_busy_idle", 64'(busy), 64'(0));
    src_load(3, 'h50, 2, 2);
    src_load(0, 'h60, 1, 1);
    apply();
    run_until(3, 100, "wrap");
    exp_beat("wrap", 0, 3, 'h50, 0);
    exp_beat("wrap", 1, 3, 'h51, 1);
    exp_beat("wrap", 2, 0, 'h60, 1);

    // Backpressure from the first beat of a 6-beat packet
    src_clear(); clear_q();
    chk("bp_busy_idle", 64'(busy), 64'(0));
    out_rdy = 1'b0;
    src_load(1, 'h10, 6, 6);
    apply();
    f0 = in_fires;
    tick(); tick();
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_stall_vld",  64'(out_vld), 64'(1));
      chk("bp_stall_data", out_data, 64'h10);
    end
    chk("bp_accepted", 64'(in_fires - f0), 64'(2));
    chk("bp_in_rdy",   64'(in_rdy), 64'(0));
    out_rdy = 1'b1;
    run_until(6, 100, "bp");
    for (int k = 0; k < 6; k++) exp_beat("bp", k, 1, DW'('h10 + k), k == 5);

    // Reset during beat 2 of a 5-beat packet
    src_clear(); clear_q();
    src_load(2, 'h20, 5, 5);
    apply();
    c = 0;
    while (src_sent[2] < 1 && c < 20) begin
      tick(); c++;
    end
    chk("mid_started", 64'(src_sent[2]), 64'(1));
    chk("mid_busy",    64'(busy), 64'(1));
    rst = 1'b0;
    tick();
    chk("mid_out_vld", 64'(out_vld), 64'(0));
    chk("mid_busy0",   64'(busy),    64'(0));
    chk("mid_in_rdy",  64'(in_rdy),  64'(0));
    src_clear();
    src_load(1, 'h70, 1, 1);
    src_load(3, 'h80, 1, 1);
    apply();
    tick();
    clear_q();
    rst = 1'b1;
    run_until(2, 50, "rerun");
    exp_beat("rerun", 0, 1, 'h70, 1);
    exp_beat("rerun", 1, 3, 'h80, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
